// File: rtl/axis_uart_rx_os_if.sv
// axis_uart_rx_os_if: AXI-Stream beat carrying one received character and its error flags
interface axis_uart_rx_os_if;
    logic [15:0] tdata;
    logic [2:0]  tuser;
    logic        tvalid;
    logic        tready;
    modport master (output tdata, tuser, tvalid, input tready);
    modport slave  (input tdata, tuser, tvalid, output tready);
endinterface

// File: rtl/axis_uart_rx_os.sv
// axis_uart_rx_os: oversampling UART receiver with majority vote, error/break flags and FWFT AXI-Stream FIFO
module axis_uart_rx_os #(
    parameter int CLK_FREQ   = 72000000,
    parameter int BAUD_RATE  = 1000000,
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              rx,
    axis_uart_rx_os_if.master m_axis,
    output logic [31:0]       rx_data_count,
    output logic              overrun,
    input  logic              overrun_clr
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int H   = OVERSAMPLE / 2;
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PH_A   = PW'(H - 1);
    localparam logic [PW-1:0] PH_B   = PW'(H);
    localparam logic [PW-1:0] PH_C   = PW'(H + 1);
    localparam logic [PW-1:0] PH_END = PW'(OVERSAMPLE - 1);

    if (DIV < 1) begin : g_div_chk
        $error("axis_uart_rx_os: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
    if (OVERSAMPLE < 4 || OVERSAMPLE > 16 || OVERSAMPLE % 2 != 0) begin : g_os_chk
        $error("axis_uart_rx_os: OVERSAMPLE must be even, 4..16");
    end
    if (DATA_BITS < 5 || DATA_BITS > 16) begin : g_db_chk
        $error("axis_uart_rx_os: DATA_BITS must be 5..16");
    end
    if (PARITY < 0 || PARITY > 4) begin : g_par_chk
        $error("axis_uart_rx_os: PARITY must be 0..4");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_sb_chk
        $error("axis_uart_rx_os: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fd_chk
        $error("axis_uart_rx_os: FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             sync_q;
    logic                   rxs_prev_q;
    logic                   rxs;
    logic [DW-1:0]          div_q;
    logic [PW-1:0]          phase_q;
    logic [1:0]             smp_q;
    logic [DATA_BITS-1:0]   data_q;
    logic [BW-1:0]          bit_cnt_q;
    logic                   stop_cnt_q;
    logic                   par_q;
    logic                   perr_q;
    logic                   ferr_q;
    logic                   tick;
    logic                   vote;
    logic                   start_det;
    logic                   smp_a;
    logic                   smp_b;
    logic                   smp_c;
    logic                   bit_end;
    logic                   last_data;
    logic                   last_stop;
    logic                   push;
    logic                   ferr_now;
    logic                   brk;
    logic                   par_err;
    logic [18:0]            mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_q;
    logic [AW-1:0]          rd_q;
    logic [AW:0]            cnt_q;
    logic                   overrun_q;
    logic                   full;
    logic                   pop;
    logic                   wr_en;
    logic                   drop;

    assign rxs = sync_q[1];

    // Two-flop synchroniser on the asynchronous pin plus a delayed copy for falling-edge detection
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_q     <= 2'b11;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[0], rx};
            rxs_prev_q <= rxs;
        end
    end

    // Baud tick divider and per-bit phase counter, both realigned to every detected start edge
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            div_q   <= '0;
            phase_q <= '0;
        end else if (start_det) begin
            div_q   <= '0;
            phase_q <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + DW'(1);
            if (tick) phase_q <= phase_q == PH_END ? '0 : phase_q + PW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: a false start aborts at the third sample, stop handling ends at mid-bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start_det) state_d = S_START;
            S_START:     if (smp_c && vote) state_d = S_IDLE; else if (bit_end) state_d = S_DATA;
            S_DATA:      if (bit_end && last_data) state_d = PARITY != 0 ? S_PARITY : S_STOP;
            S_PARITY:    if (bit_end) state_d = S_STOP;
            S_STOP:      if (push) state_d = ferr_now ? S_WAIT_HIGH : S_IDLE;
            S_WAIT_HIGH: if (rxs) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // FSM outputs: sample strobes, 2-of-3 vote, frame completion and its error flags
    always_comb begin
        tick      = div_q == DW'(DIV - 1);
        vote      = (smp_q[0] & smp_q[1]) | ((smp_q[0] | smp_q[1]) & rxs);
        start_det = state_q == S_IDLE && rxs_prev_q && !rxs;
        smp_a     = tick && phase_q == PH_A;
        smp_b     = tick && phase_q == PH_B;
        smp_c     = tick && phase_q == PH_C;
        bit_end   = tick && phase_q == PH_END;
        last_data = bit_cnt_q == BW'(DATA_BITS - 1);
        last_stop = stop_cnt_q == 1'(STOP_BITS - 1);
        push      = state_q == S_STOP && smp_c && last_stop;
        ferr_now  = ferr_q | ~vote;
        brk       = ferr_now && data_q == '0 && (PARITY == 0 || !par_q);
        par_err   = PARITY == 1 ? (^data_q) ^ vote :
                    PARITY == 2 ? ~((^data_q) ^ vote) :
                    PARITY == 3 ? ~vote :
                    PARITY == 4 ? vote : 1'b0;
    end

    // Frame assembly: first two samples held for the vote, data shifted in LSB first, flags accumulated
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            smp_q      <= 2'b11;
            data_q     <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            if (smp_a) smp_q[0] <= rxs;
            if (smp_b) smp_q[1] <= rxs;
            if (start_det) begin
                data_q     <= '0;
                bit_cnt_q  <= '0;
                stop_cnt_q <= 1'b0;
                par_q      <= 1'b0;
                perr_q     <= 1'b0;
                ferr_q     <= 1'b0;
            end
            if (state_q == S_DATA && smp_c) data_q <= {vote, data_q[DATA_BITS-1:1]};
            if (state_q == S_DATA && bit_end) bit_cnt_q <= bit_cnt_q + BW'(1);
            if (state_q == S_PARITY && smp_c) begin
                par_q  <= vote;
                perr_q <= par_err;
            end
            if (state_q == S_STOP && smp_c) ferr_q <= ferr_now;
            if (state_q == S_STOP && bit_end && !last_stop) stop_cnt_q <= 1'b1;
        end
    end

    // FIFO handshake: a full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        full  = cnt_q == (AW + 1)'(FIFO_DEPTH);
        pop   = cnt_q != '0 && m_axis.tready;
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;
    end

    // FIFO storage, unreset because only occupied entries ever reach the output
    always_ff @(posedge aclk) begin
        if (wr_en) mem_q[wr_q] <= {brk, ferr_now, perr_q, 16'(data_q)};
    end

    // FIFO pointers, occupancy and the sticky overrun flag (a drop wins over a clear)
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + AW'(1);
            if (pop)   rd_q <= rd_q + AW'(1);
            cnt_q     <= cnt_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
            overrun_q <= drop | (overrun_q & !overrun_clr);
        end
    end

    assign m_axis.tvalid = cnt_q != '0;
    assign m_axis.tdata  = m_axis.tvalid ? mem_q[rd_q][15:0] : '0;
    assign m_axis.tuser  = m_axis.tvalid ? mem_q[rd_q][18:16] : '0;
    assign rx_data_count = 32'(cnt_q);
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_axis_uart_rx_os.sv
// tb_axis_uart_rx_os: scoreboard bench for the oversampling UART receiver (even and odd parity instances)
module tb_axis_uart_rx_os;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        rx_e = 1'b1;
    logic        rx_o = 1'b1;
    logic        clr = 1'b0;
    logic [31:0] cnt_e, cnt_o;
    logic        ovr_e, ovr_o;
    int          n_vec = 0;
    int          n_err = 0;
    logic [18:0] exp_e[$];
    logic [18:0] exp_o[$];
    logic [18:0] ev, ov;

    axis_uart_rx_os_if axis_e ();
    axis_uart_rx_os_if axis_o ();

    axis_uart_rx_os #(.CLK_FREQ(80000000), .BAUD_RATE(10000000), .OVERSAMPLE(8), .DATA_BITS(8),
                      .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_even (
        .aclk(aclk), .aresetn(aresetn), .rx(rx_e), .m_axis(axis_e),
        .rx_data_count(cnt_e), .overrun(ovr_e), .overrun_clr(clr));

    axis_uart_rx_os #(.CLK_FREQ(80000000), .BAUD_RATE(10000000), .OVERSAMPLE(8), .DATA_BITS(8),
                      .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_odd (
        .aclk(aclk), .aresetn(aresetn), .rx(rx_o), .m_axis(axis_o),
        .rx_data_count(cnt_o), .overrun(ovr_o), .overrun_clr(clr));

    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    always @(negedge aclk) begin
        if (aresetn && axis_e.tvalid && axis_e.tready) begin
            n_vec++;
            if (exp_e.size() == 0) begin
                n_err++;
                $display("FAIL even_beat: got tuser=%b tdata=%h, required no beat", axis_e.tuser, axis_e.tdata);
            end else begin
                ev = exp_e.pop_front();
                if ({axis_e.tuser, axis_e.tdata} !== ev) begin
                    n_err++;
                    $display("FAIL even_beat: got tuser=%b tdata=%h, required tuser=%b tdata=%h",
                             axis_e.tuser, axis_e.tdata, ev[18:16], ev[15:0]);
                end
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn && axis_o.tvalid && axis_o.tready) begin
            n_vec++;
            if (exp_o.size() == 0) begin
                n_err++;
                $display("FAIL odd_beat: got tuser=%b tdata=%h, required no beat", axis_o.tuser, axis_o.tdata);
            end else begin
                ov = exp_o.pop_front();
                if ({axis_o.tuser, axis_o.tdata} !== ov) begin
                    n_err++;
                    $display("FAIL odd_beat: got tuser=%b tdata=%h, required tuser=%b tdata=%h",
                             axis_o.tuser, axis_o.tdata, ov[18:16], ov[15:0]);
                end
            end
        end
    end

    function automatic logic epar(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic drive(input bit odd, input logic b, input int bits);
        if (odd) rx_o = b;
        else     rx_e = b;
        repeat (bits * 8) @(negedge aclk);
    endtask

    task automatic send_frame(input bit odd, input logic [7:0] d, input logic p, input logic s);
        drive(odd, 1'b0, 1);
        for (int i = 0; i < 8; i++) drive(odd, d[i], 1);
        drive(odd, p, 1);
        drive(odd, s, 1);
    endtask

    task automatic wait_idle(input int max);
        for (int k = 0; k < max && (exp_e.size() != 0 || exp_o.size() != 0); k++) @(negedge aclk);
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        n_vec++;
        if ({axis_e.tvalid, axis_e.tdata, axis_e.tuser, cnt_e, ovr_e} !== '0) begin
            n_err++;
            $display("FAIL reset_even: got tvalid=%b tdata=%h tuser=%b count=%0d overrun=%b, required all 0",
                     axis_e.tvalid, axis_e.tdata, axis_e.tuser, cnt_e, ovr_e);
        end
        n_vec++;
        if ({axis_o.tvalid, axis_o.tdata, axis_o.tuser, cnt_o, ovr_o} !== '0) begin
            n_err++;
            $display("FAIL reset_odd: got tvalid=%b tdata=%h tuser=%b count=%0d overrun=%b, required all 0",
                     axis_o.tvalid, axis_o.tdata, axis_o.tuser, cnt_o, ovr_o);
        end
        aresetn = 1'b1;
        drive(0, 1'b1, 2);
    endtask

    task automatic test_even_parity;
        logic [7:0] d = 8'hA5;
        exp_e.push_back({3'b000, 16'h00A5});
        send_frame(0, d, epar(d), 1'b1);
        drive(0, 1'b1, 1);
        wait_idle(40);
        n_vec++;
        if (exp_e.size() !== 0) begin
            n_err++;
            $display("FAIL even_a5_delivered: %0d beats outstanding, required 0", exp_e.size());
        end
        n_vec++;
        if (cnt_e !== 32'd0) begin
            n_err++;
            $display("FAIL even_a5_count: got %0d, required 0", cnt_e);
        end
    endtask

    task automatic test_odd_parity;
        logic [7:0] d = 8'h3C;
        for (int p = 0; p < 2; p++) begin
            exp_o.push_back({2'b00, ~(epar(d) ^ 1'(p)), 16'h003C});
            send_frame(1, d, 1'(p), 1'b1);
        end
        drive(1, 1'b1, 2);
        wait_idle(40);
        n_vec++;
        if (exp_o.size() !== 0) begin
            n_err++;
            $display("FAIL odd_3c_delivered: %0d beats outstanding, required 0", exp_o.size());
        end
    endtask

    task automatic test_framing_break;
        logic [7:0] d = 8'h55;
        exp_e.push_back({3'b010, 16'h0055});
        send_frame(0, d, epar(d), 1'b0);
        drive(0, 1'b1, 2);
        wait_idle(40);
        n_vec++;
        if (exp_e.size() !== 0) begin
            n_err++;
            $display("FAIL framing_delivered: %0d beats outstanding, required 0", exp_e.size());
        end
        exp_e.push_back({3'b110, 16'h0000});
        drive(0, 1'b0, 40);
        drive(0, 1'b1, 4);
        wait_idle(40);
        n_vec++;
        if (exp_e.size() !== 0) begin
            n_err++;
            $display("FAIL break_delivered: %0d beats outstanding, required 0", exp_e.size());
        end
        n_vec++;
        if (cnt_e !== 32'd0) begin
            n_err++;
            $display("FAIL break_single_beat: count=%0d, required 0", cnt_e);
        end
    endtask

    task automatic test_glitch;
        logic [7:0] d = 8'h81;
        rx_e = 1'b0;
        repeat (3) @(negedge aclk);
        rx_e = 1'b1;
        repeat (24) @(negedge aclk);
        n_vec++;
        if ({axis_e.tvalid, cnt_e} !== 33'd0) begin
            n_err++;
            $display("FAIL glitch_reject: got tvalid=%b count=%0d, required 0/0", axis_e.tvalid, cnt_e);
        end
        exp_e.push_back({3'b000, 16'h0081});
        send_frame(0, d, epar(d), 1'b1);
        drive(0, 1'b1, 2);
        wait_idle(40);
        n_vec++;
        if (exp_e.size() !== 0) begin
            n_err++;
            $display("FAIL glitch_then_81: %0d beats outstanding, required 0", exp_e.size());
        end
    endtask

    task automatic test_overrun;
        axis_e.tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            logic [7:0] d;
            d = 8'(i);
            if (i < 16) exp_e.push_back({3'b000, 8'h00, d});
            send_frame(0, d, epar(d), 1'b1);
        end
        drive(0, 1'b1, 2);
        n_vec++;
        if (cnt_e !== 32'd16) begin
            n_err++;
            $display("FAIL overrun_count: got %0d, required 16", cnt_e);
        end
        n_vec++;
        if (ovr_e !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_set: got %b, required 1", ovr_e);
        end
        repeat (4) @(negedge aclk);
        n_vec++;
        if ({axis_e.tvalid, axis_e.tuser, axis_e.tdata} !== {1'b1, 3'b000, 16'h0000}) begin
            n_err++;
            $display("FAIL overrun_head_hold: got tvalid=%b tuser=%b tdata=%h, required 1/000/0000",
                     axis_e.tvalid, axis_e.tuser, axis_e.tdata);
        end
        axis_e.tready = 1'b1;
        wait_idle(64);
        n_vec++;
        if (exp_e.size() !== 0) begin
            n_err++;
            $display("FAIL overrun_drain: %0d beats outstanding, required 0", exp_e.size());
        end
        n_vec++;
        if ({cnt_e, ovr_e} !== {32'd0, 1'b1}) begin
            n_err++;
            $display("FAIL overrun_sticky: got count=%0d overrun=%b, required 0/1", cnt_e, ovr_e);
        end
        clr = 1'b1;
        @(negedge aclk);
        clr = 1'b0;
        n_vec++;
        if (ovr_e !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_clear: got %b, required 0", ovr_e);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d = 8'h34;
        axis_e.tready = 1'b0;
        send_frame(0, 8'h01, 1'b1, 1'b1);
        send_frame(0, 8'h02, 1'b1, 1'b1);
        drive(0, 1'b1, 1);
        n_vec++;
        if (cnt_e !== 32'd2) begin
            n_err++;
            $display("FAIL reset_mid_queued: got %0d, required 2", cnt_e);
        end
        drive(0, 1'b0, 1);
        drive(0, 1'b0, 1);
        drive(0, 1'b1, 1);
        drive(0, 1'b0, 1);
        aresetn = 1'b0;
        #1;
        n_vec++;
        if ({axis_e.tvalid, axis_e.tdata, axis_e.tuser, cnt_e, ovr_e} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got tvalid=%b tdata=%h tuser=%b count=%0d overrun=%b, required all 0",
                     axis_e.tvalid, axis_e.tdata, axis_e.tuser, cnt_e, ovr_e);
        end
        rx_e = 1'b1;
        repeat (4) @(negedge aclk);
        aresetn = 1'b1;
        drive(0, 1'b1, 2);
        axis_e.tready = 1'b1;
        exp_e.push_back({3'b000, 16'h0034});
        send_frame(0, d, epar(d), 1'b1);
        drive(0, 1'b1, 2);
        wait_idle(40);
        n_vec++;
        if ({exp_e.size() == 0, cnt_e} !== {1'b1, 32'd0}) begin
            n_err++;
            $display("FAIL reset_mid_fresh_34: outstanding=%0d count=%0d, required 0/0", exp_e.size(), cnt_e);
        end
    endtask

    initial begin
        axis_e.tready = 1'b1;
        axis_o.tready = 1'b1;
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_framing_break();
        test_glitch();
        test_overrun();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
